// File: rtl/tx_packet_framer_pkg.sv
// rtl/tx_packet_framer_pkg.sv - shared state encoding and constants for the transmit packet framer
package tx_packet_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_TAIL     = 3'd4
    } tx_state_e;

    localparam int SYNC_LEN = 16;
    localparam logic [SYNC_LEN-1:0] DEFAULT_SYNC_WORD = 16'hD391;

    // One tick holds the last symbol, the next one closes the packet.
    localparam int TAIL_TICKS = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_symbol_counter.sv
// rtl/tx_symbol_counter.sv - loadable symbol down-counter with terminal-count flag
module tx_symbol_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load wins over a coincident tick; the count saturates at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/tx_packet_framer.sv
// rtl/tx_packet_framer.sv - BPSK transmit framer: preamble, optional sync word (TX_SYNC_WORD_EN), payload, tail
module tx_packet_framer
    import tx_packet_framer_pkg::*;
#(
    parameter int                    MAX_WINDOW_WIDTH = 8,
    parameter int                    LEN_WIDTH        = 16,
    parameter logic [SYNC_LEN-1:0]   SYNC_WORD        = DEFAULT_SYNC_WORD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_WINDOW_WIDTH-1:0] TX_PD_LEN,
    input  logic [LEN_WIDTH-1:0]        TX_PAYLOAD_LEN,
    input  logic                        start,
    input  logic                        symbol_tick,
    input  logic                        data_bit,
    input  logic                        data_valid,
    output logic                        data_ready,
    output logic                        BPSK,
    output logic                        tx_en,
    output logic                        busy,
    output logic                        done,
    output logic                        underrun
);

    localparam int CNT_W = max_int(max_int(LEN_WIDTH, MAX_WINDOW_WIDTH), $clog2(SYNC_LEN + 1));

    tx_state_e              state_q, state_d;
    logic [LEN_WIDTH-1:0]   pl_len_q, pl_len_d;
    logic                   bpsk_q, bpsk_d;
    logic                   tx_en_q, tx_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   underrun_q, underrun_d;

    logic                   cnt_load;
    logic [CNT_W-1:0]       cnt_load_val;
    logic                   cnt_tc;
    logic                   phase_end;

    logic [LEN_WIDTH-1:0]   pl_src;
    tx_state_e              after_pre_state;
    tx_state_e              after_sync_state;

    // Payload length comes straight from the input while the start is being accepted.
    assign pl_src           = (state_q == ST_IDLE) ? TX_PAYLOAD_LEN : pl_len_q;
    assign after_sync_state = (pl_src != '0) ? ST_PAYLOAD : ST_TAIL;
    assign phase_end        = symbol_tick && cnt_tc;

`ifdef TX_SYNC_WORD_EN
    logic [SYNC_LEN-1:0] sync_sr_q, sync_sr_d;

    assign after_pre_state = ST_SYNC;

    always_comb begin
        sync_sr_d = sync_sr_q;
        if (cnt_load && (state_d == ST_SYNC)) begin
            sync_sr_d = SYNC_WORD;
        end else if ((state_q == ST_SYNC) && symbol_tick) begin
            sync_sr_d = {sync_sr_q[SYNC_LEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_sr_q <= '0;
        end else begin
            sync_sr_q <= sync_sr_d;
        end
    end
`else
    logic [SYNC_LEN-1:0] sync_word_unused;

    assign sync_word_unused = SYNC_WORD;
    assign after_pre_state  = after_sync_state;
`endif

    always_comb begin
        state_d    = state_q;
        pl_len_d   = pl_len_q;
        bpsk_d     = bpsk_q;
        tx_en_d    = tx_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        cnt_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                bpsk_d  = 1'b0;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    pl_len_d   = TX_PAYLOAD_LEN;
                    underrun_d = 1'b0;
                    busy_d     = 1'b1;
                    cnt_load   = 1'b1;
                    state_d    = (TX_PD_LEN != '0) ? ST_PREAMBLE : after_pre_state;
                end
            end
            ST_PREAMBLE: begin
                if (symbol_tick) begin
                    // Preamble always starts from the idle level 0, so toggling yields 1,0,1,...
                    bpsk_d  = ~bpsk_q;
                    tx_en_d = 1'b1;
                end
                if (phase_end) begin
                    cnt_load = 1'b1;
                    state_d  = after_pre_state;
                end
            end
`ifdef TX_SYNC_WORD_EN
            ST_SYNC: begin
                if (symbol_tick) begin
                    bpsk_d  = sync_sr_q[SYNC_LEN-1];
                    tx_en_d = 1'b1;
                end
                if (phase_end) begin
                    cnt_load = 1'b1;
                    state_d  = after_sync_state;
                end
            end
`endif
            ST_PAYLOAD: begin
                if (symbol_tick) begin
                    bpsk_d  = data_valid & data_bit;
                    tx_en_d = 1'b1;
                    if (!data_valid) begin
                        underrun_d = 1'b1;
                    end
                end
                if (phase_end) begin
                    cnt_load = 1'b1;
                    state_d  = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (phase_end) begin
                    bpsk_d  = 1'b0;
                    tx_en_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (symbol_tick) begin
                    tx_en_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        unique case (state_d)
            ST_PREAMBLE: cnt_load_val = CNT_W'(TX_PD_LEN);
            ST_SYNC:     cnt_load_val = CNT_W'(SYNC_LEN);
            ST_PAYLOAD:  cnt_load_val = CNT_W'(pl_src);
            default:     cnt_load_val = CNT_W'(TAIL_TICKS);
        endcase
    end

    tx_symbol_counter #(
        .WIDTH (CNT_W)
    ) u_symbol_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_val),
        .tick       (symbol_tick),
        .tc         (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pl_len_q   <= '0;
            bpsk_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pl_len_q   <= pl_len_d;
            bpsk_q     <= bpsk_d;
            tx_en_q    <= tx_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign data_ready = (state_q == ST_PAYLOAD) && symbol_tick;
    assign BPSK       = bpsk_q;
    assign tx_en      = tx_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_tx_packet_framer.sv
// tb/tb_tx_packet_framer.sv - directed self-checking bench for tx_packet_framer
module tb_tx_packet_framer;

    localparam logic [15:0] SW = 16'hD391;
`ifdef TX_SYNC_WORD_EN
    localparam int SYNC_N = 16;
`else
    localparam int SYNC_N = 0;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  TX_PD_LEN;
    logic [15:0] TX_PAYLOAD_LEN;
    logic        start;
    logic        symbol_tick;
    logic        data_bit;
    logic        data_valid;
    logic        data_ready;
    logic        BPSK;
    logic        tx_en;
    logic        busy;
    logic        done;
    logic        underrun;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    tx_packet_framer #(
        .MAX_WINDOW_WIDTH (8),
        .LEN_WIDTH        (16),
        .SYNC_WORD        (SW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .TX_PD_LEN      (TX_PD_LEN),
        .TX_PAYLOAD_LEN (TX_PAYLOAD_LEN),
        .start          (start),
        .symbol_tick    (symbol_tick),
        .data_bit       (data_bit),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .BPSK           (BPSK),
        .tx_en          (tx_en),
        .busy           (busy),
        .done           (done),
        .underrun       (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    // One packet with a tick every 4 cycles; abort_at >= 0 resets the DUT in place of that tick.
    task automatic run_packet(input int pd, input int pl, input logic [15:0] bits,
                              input logic [15:0] valid, input bit tick_at_start,
                              input bit poke, input int abort_at, input bit check_lock);
        int   n;
        int   d0;
        int   pidx;
        int   alt;
        bit   in_pl;
        bit   lock;
        logic last;
        logic exp_b;
        logic prev;
        n     = pd + SYNC_N + pl + 1;
        d0    = done_cnt;
        last  = 1'b0;
        prev  = 1'b0;
        alt   = 0;
        lock  = 1'b0;
        next_cyc();
        TX_PD_LEN      = pd[7:0];
        TX_PAYLOAD_LEN = pl[15:0];
        start          = 1'b1;
        symbol_tick    = tick_at_start;
        next_cyc();
        start          = 1'b0;
        symbol_tick    = 1'b0;
        TX_PD_LEN      = 8'd3;
        TX_PAYLOAD_LEN = 16'd7;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        chk("underrun_clr", {31'd0, underrun}, 32'd0);
        chk("pre_first_tick", {30'd0, tx_en, BPSK}, 32'd0);
        for (int k = 0; k <= n; k++) begin
            next_cyc();
            if (poke && k == 0) begin
                start          = 1'b1;
                TX_PD_LEN      = 8'd5;
                TX_PAYLOAD_LEN = 16'd3;
            end
            next_cyc();
            start = 1'b0;
            if (k == abort_at) begin
                rst   = 1'b1;
                start = 1'b1;
                next_cyc();
                rst   = 1'b0;
                start = 1'b0;
                chk("abort_outs", {26'd0, BPSK, tx_en, busy, done, underrun, data_ready}, 32'd0);
                next_cyc();
                chk("abort_idle", {30'd0, busy, tx_en}, 32'd0);
                chk("abort_no_done", done_cnt - d0, 32'd0);
                return;
            end
            next_cyc();
            pidx        = k - pd - SYNC_N;
            in_pl       = (pidx >= 0) && (pidx < pl);
            symbol_tick = 1'b1;
            data_bit    = in_pl ? bits[pidx] : 1'($urandom_range(0, 1));
            data_valid  = in_pl ? valid[pidx] : 1'b1;
            #1;
            chk($sformatf("data_ready_k%0d", k), {31'd0, data_ready}, {31'd0, in_pl});
            next_cyc();
            symbol_tick = 1'b0;
            data_valid  = 1'b0;
            data_bit    = 1'b0;
            if (k < n) begin
                if (k < pd)               exp_b = (k % 2 == 0);
                else if (k < pd + SYNC_N) exp_b = SW[15 - (k - pd)];
                else if (in_pl)           exp_b = bits[pidx] & valid[pidx];
                else                      exp_b = last;
                last = exp_b;
                chk($sformatf("sym_k%0d", k), {29'd0, tx_en, BPSK, done}, {29'd0, 1'b1, exp_b, 1'b0});
                if (k < pd) begin
                    alt  = (k > 0 && BPSK != prev) ? alt + 1 : 1;
                    prev = BPSK;
                    if (alt >= 8) lock = 1'b1;
                end
            end else begin
                chk("pkt_end", {28'd0, tx_en, BPSK, busy, done}, 32'd1);
            end
        end
        next_cyc();
        chk("done_low", {31'd0, done}, 32'd0);
        chk("done_once", done_cnt - d0, 32'd1);
        if (check_lock) chk("pd_lock", {31'd0, lock}, 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        symbol_tick    = 1'b0;
        data_bit       = 1'b0;
        data_valid     = 1'b0;
        TX_PD_LEN      = 8'd0;
        TX_PAYLOAD_LEN = 16'd0;
        repeat (3) next_cyc();
        chk("reset_outs", {26'd0, BPSK, tx_en, busy, done, underrun, data_ready}, 32'd0);
        rst = 1'b0;
        next_cyc();

        // Source 1,1,0,1; tick coincident with start must be ignored.
        run_packet(8, 4, 16'h000B, 16'h000F, 1'b1, 1'b0, -1, 1'b0);

        // All-ones source with the third bit missing.
        run_packet(8, 4, 16'h000F, 16'h000B, 1'b0, 1'b0, -1, 1'b0);
        repeat (5) next_cyc();
        chk("underrun_sticky", {31'd0, underrun}, 32'd1);

        // Empty packet, with a start poked while busy.
        run_packet(0, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, -1, 1'b0);

        // Reset mid-preamble (with a coincident start), then a clean packet.
        run_packet(8, 4, 16'h000B, 16'h000F, 1'b0, 1'b0, 3, 1'b0);
        run_packet(8, 4, 16'h000B, 16'h000F, 1'b0, 1'b0, -1, 1'b0);

        // Longer preamble into a window-8 alternation detector.
        run_packet(12, 2, 16'h0002, 16'h0003, 1'b0, 1'b0, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
